// File: rtl/serial_adder_carry.sv
// Bit-serial adder: one carry cell plus shift registers. The optional
// SERIAL_ADDER_CARRY_SUB_EN build adds a 'sub' input for subtraction with borrow-in.
module serial_adder_carry #(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_CARRY_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             p, g, cell_sum, cell_cout;
  logic [WIDTH:0]   sum_cat;

`ifdef SERIAL_ADDER_CARRY_SUB_EN
  // Subtraction is a + ~b + ~cin; carry-out then reads as "no borrow".
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub ? ~cin : cin;
`else
  assign b_ld = b;
  assign c_ld = cin;
`endif

  assign p       = a_sh[0] ^ b_sh[0];
  assign g       = a_sh[0] & b_sh[0];
  assign accept  = in_valid && in_ready;
  // Concatenate then drop the LSB so the shift also works when WIDTH==1.
  assign sum_cat = {cell_sum, sum};

  adder_carry u_cell (
    .p      (p),
    .g      (g),
    .cin    (carry),
    .sumout (cell_sum),
    .cout   (cell_cout)
  );

  always_ff @(posedge C or negedge R) begin
    if (!R) state <= IDLE;
    else    state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_nx = in_valid ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      // Also retires a pending result when accepted from DONE.
      a_sh      <= a;
      b_sh      <= b_ld;
      carry     <= c_ld;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (state == RUN) begin
      sum   <= sum_cat[WIDTH:1];
      carry <= cell_cout;
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      cnt   <= cnt + 1'b1;
      if (cnt == LAST) begin
        cout      <= cell_cout;
        out_valid <= 1'b1;
      end
    end else if (state == DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// Single-bit carry cell driven by propagate/generate.
module adder_carry (
  input  logic p,
  input  logic g,
  input  logic cin,
  output logic sumout,
  output logic cout
);
  assign sumout = p ^ cin;
  assign cout   = g | (p & cin);
endmodule

// File: tb/tb_serial_adder_carry.sv
// Self-checking bench for serial_adder_carry (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder_carry;
  logic C = 1'b0;
  logic R = 1'b0;
  always #5 C = ~C;

  logic       iv = 0, ir, ov, ordy = 0, ci = 0, co, sb = 0;
  logic [7:0] a = 0, b = 0, s;
  logic       iv1 = 0, ir1, ov1, ordy1 = 0, ci1 = 0, co1, sb1 = 0;
  logic [0:0] a1 = 0, b1 = 0, s1;

  int total = 0;
  int bad   = 0;

  serial_adder_carry #(.WIDTH(8)) dut (
    .C(C), .R(R), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .cin(ci),
`ifdef SERIAL_ADDER_CARRY_SUB_EN
    .sub(sb),
`endif
    .out_valid(ov), .out_ready(ordy), .sum(s), .cout(co)
  );

  serial_adder_carry #(.WIDTH(1)) dut1 (
    .C(C), .R(R), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(ci1),
`ifdef SERIAL_ADDER_CARRY_SUB_EN
    .sub(sb1),
`endif
    .out_valid(ov1), .out_ready(ordy1), .sum(s1), .cout(co1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic; returns {cout, sum[7:0]}.
  function automatic logic [8:0] model(input int x, input int y, input int c, input logic sub);
    int r;
    logic [8:0] res;
    if (!sub) begin
      r   = x + y + c;
      res = r[8:0];
    end else begin
      r   = x - y - c;
      res = {(r >= 0), r[7:0]};
    end
    return res;
  endfunction

  logic [8:0] exp_r;

  task automatic start(input logic [7:0] xa, input logic [7:0] xb, input logic xc, input logic xs);
    int n = 0;
    while (!ir && n < 100) begin @(negedge C); n++; end
    chk("in_ready_wait", {63'd0, (n < 100)}, 64'd1);
    iv = 1; a = xa; b = xb; ci = xc; sb = xs;
    exp_r = model(int'(xa), int'(xb), int'(xc), xs);
    @(negedge C);
    iv = 0;
  endtask

  // Called at the negedge right after the accepting edge.
  task automatic wait_done(input string tag);
    int n = 0;
    while (!ov && n < 100) begin
      // Noise during RUN must be ignored.
      iv = $urandom_range(0, 1);
      a  = 8'($urandom);
      b  = 8'($urandom);
      ci = 1'($urandom);
      if (n == 2) chk({tag, "_ready_run"}, {63'd0, ir}, 64'd0);
      @(negedge C);
      n++;
    end
    iv = 0;
    chk({tag, "_latency"}, 64'(n), 64'd8);
    chk({tag, "_sum"}, {56'd0, s}, {56'd0, exp_r[7:0]});
    chk({tag, "_cout"}, {63'd0, co}, {63'd0, exp_r[8]});
  endtask

  task automatic retire(input string tag);
    ordy = 1;
    @(negedge C);
    ordy = 0;
    chk({tag, "_valid_drop"}, {63'd0, ov}, 64'd0);
    chk({tag, "_ready_idle"}, {63'd0, ir}, 64'd1);
  endtask

  initial begin
    logic [7:0] hs;
    logic       hc;
    // Reset state
    repeat (2) @(negedge C);
    chk("rst_valid", {63'd0, ov}, 64'd0);
    chk("rst_sum", {56'd0, s}, 64'd0);
    chk("rst_cout", {63'd0, co}, 64'd0);
    chk("rst_ready", {63'd0, ir}, 64'd1);
    R = 1;
    @(negedge C);

    // Basic add plus 5 cycles of backpressure
    start(8'h3C, 8'h5A, 1'b0, 1'b0);
    wait_done("add3c5a");
    chk("add3c5a_abs", {56'd0, s}, 64'h96);
    hs = s; hc = co;
    repeat (5) begin
      @(negedge C);
      chk("bp_ready", {63'd0, ir}, 64'd0);
    end
    chk("bp_sum", {56'd0, s}, {56'd0, hs});
    chk("bp_cout", {63'd0, co}, {63'd0, hc});
    chk("bp_valid", {63'd0, ov}, 64'd1);
    retire("r1");

    start(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done("ff01");
    retire("r2");
    start(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_done("ffff1");
    chk("ffff1_abs", {55'd0, co, s}, 64'h1FF);

    // Back-to-back: retire and accept on the same edge
    ordy = 1; iv = 1; a = 8'h01; b = 8'h02; ci = 0; sb = 0;
    exp_r = model(1, 2, 0, 1'b0);
    @(negedge C);
    ordy = 0; iv = 0;
    chk("b2b_valid_drop", {63'd0, ov}, 64'd0);
    wait_done("b2b");
    retire("r3");

    // Asynchronous reset mid-operation
    start(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) @(negedge C);
    #2 R = 0;
    #1;
    chk("arst_sum", {56'd0, s}, 64'd0);
    chk("arst_cout", {63'd0, co}, 64'd0);
    chk("arst_valid", {63'd0, ov}, 64'd0);
    @(negedge C);
    R = 1;
    @(negedge C);
    chk("arst_ready", {63'd0, ir}, 64'd1);
    chk("arst_no_pulse", {63'd0, ov}, 64'd0);
    start(8'h01, 8'h01, 1'b0, 1'b0);
    wait_done("post_rst");
    retire("r4");

    // Random operands with random backpressure
    for (int i = 0; i < 20; i++) begin
      logic rs;
`ifdef SERIAL_ADDER_CARRY_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      start(8'($urandom), 8'($urandom), 1'($urandom), rs);
      wait_done("rand");
      repeat ($urandom_range(0, 3)) @(negedge C);
      chk("rand_hold", {55'd0, co, s}, {55'd0, exp_r});
      retire("rand");
    end

`ifdef SERIAL_ADDER_CARRY_SUB_EN
    start(8'h10, 8'h01, 1'b0, 1'b1);
    wait_done("sub10_01");
    chk("sub10_01_abs", {55'd0, co, s}, 64'h10F);
    retire("r5");
    start(8'h00, 8'h01, 1'b0, 1'b1);
    wait_done("sub00_01");
    chk("sub00_01_abs", {55'd0, co, s}, 64'h0FF);
    retire("r6");
    sb = 0;
`endif

    // WIDTH=1 instance: one-cycle latency
    chk("w1_ready", {63'd0, ir1}, 64'd1);
    iv1 = 1; a1 = 1; b1 = 1; ci1 = 1;
    @(negedge C);
    iv1 = 0;
    chk("w1_not_yet", {63'd0, ov1}, 64'd0);
    @(negedge C);
    chk("w1_valid", {63'd0, ov1}, 64'd1);
    chk("w1_sum_cout", {62'd0, co1, s1}, 64'd3);
    ordy1 = 1; iv1 = 1; a1 = 1; b1 = 0; ci1 = 0;
    @(negedge C);
    ordy1 = 0; iv1 = 0;
    @(negedge C);
    chk("w1_b2b_valid", {63'd0, ov1}, 64'd1);
    chk("w1_b2b_sum_cout", {62'd0, co1, s1}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
